// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the chunked pipelined adder: default geometry and
// the op_sub encoding.
package pipelined_adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;
endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple-carry slice. It also exposes the carry
// into its top bit, so that the slice holding the word MSB can produce the
// signed overflow flag.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out,
  output logic             carry_msb
);
  logic [CHUNK:0] c;

  // ripple the carry through the slice, starting from bit 0
  always_comb begin
    c    = '0;
    c[0] = carry_in;
    for (int i = 0; i < CHUNK; i++)
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign sum       = a ^ b ^ c[CHUNK-1:0];
  assign carry_out = c[CHUNK];
  assign carry_msb = c[CHUNK-1];
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/sub. Each stage adds one CHUNK of the operands. The operand
// chunks that are still to be added ride along in skew registers, and the
// result chunks already produced ride along in deskew registers, so that the
// whole word leaves the last stage together. One global enable stalls every
// stage at once when the output is blocked.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int STAGES = WIDTH / CHUNK;

  logic                         en;
  logic [STAGES-1:0]            vld_q;
  logic [STAGES:0]              vld_pipe;

  // registered state per stage
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, r_q;
  logic [STAGES-1:0]            c_q;
  logic                         ovf_q;

  // combinational stage inputs and results
  logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_r, r_nxt;
  logic [STAGES-1:0]            st_c;
  logic [STAGES-1:0][CHUNK-1:0] s_chk;
  logic [STAGES-1:0]            co_chk, cm_chk;

  // Low chunks of the skew registers, the last stage's operand copy and the
  // carry-into-MSB of the inner slices are never consumed.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, cm_chk};

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign vld_pipe = {vld_q, in_valid};

  // Stage 0 takes the raw operands. Subtract is A + ~B + 1, so B is
  // inverted and the carry is forced to 1. Later stages take the previous
  // stage's registers.
  always_comb begin
    st_a    = '0;
    st_b    = '0;
    st_r    = '0;
    st_c    = '0;
    st_a[0] = a;
    st_b[0] = (op_e'(op_sub) == OP_SUB) ? ~b : b;
    st_c[0] = (op_e'(op_sub) == OP_SUB) ? 1'b1 : carry_in;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_r[k] = r_q[k-1];
      st_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    chunk_adder #(.CHUNK(CHUNK)) u_add (
      .a         (st_a[k][k*CHUNK +: CHUNK]),
      .b         (st_b[k][k*CHUNK +: CHUNK]),
      .carry_in  (st_c[k]),
      .sum       (s_chk[k]),
      .carry_out (co_chk[k]),
      .carry_msb (cm_chk[k])
    );
  end

  // merge each stage's new chunk into the partial result it passes on
  always_comb begin
    r_nxt = st_r;
    for (int k = 0; k < STAGES; k++)
      r_nxt[k][k*CHUNK +: CHUNK] = s_chk[k];
  end

  // advance every stage together when enabled and hold them all otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= vld_pipe[STAGES-1:0];
      a_q   <= st_a;
      b_q   <= st_b;
      r_q   <= r_nxt;
      c_q   <= co_chk;
      ovf_q <= cm_chk[STAGES-1] ^ co_chk[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = r_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ovf_q;
  // qualified by valid so that reset (sum = 0) reports zero = 0
  assign zero      = out_valid & ~|r_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, CHUNK=4, latency 4).
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        carry_in, op_sub, carry_out, overflow, zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov, z;
  } vec_t;

  vec_t tbl[10];

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // reference: {zero, overflow, carry_out, sum}
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin, input logic sub);
    logic [15:0] yy;
    logic [16:0] full;
    logic        ov;
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, (sub ? 1'b1 : cin)};
    ov   = (x[15] == yy[15]) && (full[15] != x[15]);
    return {(full[15:0] == 16'd0), ov, full[16], full[15:0]};
  endfunction

  // one isolated operation: checks exact latency and all result fields
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    a = v.a; b = v.b; carry_in = v.cin; op_sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk($sformatf("v%0d_in_ready", idx), in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 3) chk($sformatf("v%0d_early_valid", idx), out_valid, 0);
      if (i == 4) begin
        chk($sformatf("v%0d_valid", idx), out_valid, 1);
        chk($sformatf("v%0d_sum", idx), sum, v.s);
        chk($sformatf("v%0d_carry", idx), carry_out, v.co);
        chk($sformatf("v%0d_ovf", idx), overflow, v.ov);
        chk($sformatf("v%0d_zero", idx), zero, v.z);
      end
    end
  endtask

  initial begin
    logic [15:0] sa[8], sb[8];
    logic        scin[8], ssub[8];
    logic [18:0] q[$];
    logic [18:0] held, expv;
    logic        held_vld;
    logic        stale;
    int          sent, got;

    //            a         b        cin   sub   sum       co    ov    z
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    // reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; carry_in = 1'b0; op_sub = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {sum, carry_out, overflow, zero}, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // isolated directed vectors
    foreach (tbl[i]) run_vec(tbl[i], i);

    // stream 8 ops back-to-back with a 3-cycle output stall
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom);
      scin[i] = 1'($urandom); ssub[i] = 1'($urandom);
    end
    sent = 0; got = 0; held_vld = 1'b0; held = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      if (sent < 8) begin
        a = sa[sent]; b = sb[sent]; carry_in = scin[sent]; op_sub = ssub[sent];
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      chk("in_ready_eq_en", in_ready, out_ready || !out_valid);
      if (c >= 5 && c <= 7) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
      end
      if (held_vld) chk("stall_hold", {zero, overflow, carry_out, sum}, held);
      held_vld = out_valid && !out_ready;
      held     = {zero, overflow, carry_out, sum};
      if (in_valid && in_ready) begin
        q.push_back(model(sa[sent], sb[sent], scin[sent], ssub[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stream_extra_result", 1, 0);
        else begin
          expv = q.pop_front();
          chk($sformatf("stream_res%0d", got), {zero, overflow, carry_out, sum}, expv);
        end
        got++;
      end
    end
    chk("stream_count", got, 8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("stream_drained", out_valid, 0);

    // reset with one result at the output and three in flight
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      a = 16'h1234 + 16'(j); b = 16'h1111; carry_in = 1'b0; op_sub = 1'b0;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_flags", {carry_out, overflow, zero}, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_after_rst", stale, 0);
    run_vec(tbl[2], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of CHUNK and at least 4.
REQ-002 Parameter CHUNK, default 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK is derived, not a parameter.
REQ-003 Port clk, input, 1: single clock, all state rising-edge triggered.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1: operand set presented.
REQ-006 Port in_ready, output, 1: pipeline accepts operands this cycle.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port carry_in, input, 1: carry into bit 0 in add mode; ignored in sub mode.
REQ-010 Port op_sub, input, 1: 0 = A+B+carry_in, 1 = A-B.
REQ-011 Port out_valid, output, 1: result present.
REQ-012 Port out_ready, input, 1: downstream accepts result.
REQ-013 Port sum, output, WIDTH: result.
REQ-014 Port carry_out, output, 1: carry out of MSB; in sub mode 1 = no borrow.
REQ-015 Port overflow, output, 1: two's-complement signed overflow.
REQ-016 Port zero, output, 1: sum == 0.

Function
REQ-017 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-018 Global advance enable en = out_ready || !out_valid; in_ready SHALL equal en, combinationally.
REQ-019 When en = 0 every stage register SHALL hold; when en = 1 every stage SHALL shift one place, stage 0 loading the input (valid = in_valid).
REQ-020 Stage k SHALL add operand bits [k*CHUNK +: CHUNK] with the carry registered from stage k-1 (stage 0: effective carry-in); higher operand chunks and lower result chunks are carried forward in registers (skew/deskew).
REQ-021 Sub mode: B SHALL be bitwise inverted and effective carry-in forced to 1 at stage 0.
REQ-022 Latency: result of an operand accepted at edge N SHALL appear with out_valid = 1 after edge N+STAGES-1, provided en = 1 throughout.
REQ-023 Throughput one operation per cycle while out_ready = 1; bubbles (in_valid = 0) propagate and are not collapsed.
REQ-024 overflow SHALL equal (carry into MSB) XOR carry_out; zero SHALL be computed from the final registered sum.
REQ-025 Results SHALL leave in acceptance order; no operation may be dropped or duplicated under any out_ready pattern.
REQ-026 sum, carry_out, overflow, zero SHALL be stable while out_valid && !out_ready.
REQ-027 Arithmetic wraps modulo 2^WIDTH; no saturation.

Reset
REQ-028 rst_n low SHALL clear all stage valid bits immediately; out_valid = 0, sum = 0, carry_out = 0, overflow = 0, zero = 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; none may emerge after release.
REQ-030 in_ready SHALL be 1 during and after reset when out_ready is 1 or out_valid is 0 (per REQ-018).

Structure
REQ-031 Package pipelined_adder_pkg SHALL hold default WIDTH/CHUNK constants and the op encoding (OP_ADD = 0, OP_SUB = 1).
REQ-032 Sub-module chunk_adder (CHUNK-bit combinational ripple-carry slice, outputs sum, carry-out, carry into its MSB) SHALL be instantiated once per stage.
REQ-033 No combinational path from a/b to sum; only in_ready depends combinationally on out_ready.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-034 Add 0xFFFF + 0x0001, carry_in=0 -> 4 cycles later sum=0x0000, carry_out=1, overflow=0, zero=1.
REQ-035 Add 0x7FFF + 0x0001 -> sum=0x8000, carry_out=0, overflow=1; add 0x1234+0x1111, carry_in=1 -> 0x2346.
REQ-036 Sub 0x0005 - 0x0007 -> sum=0xFFFE, carry_out=0, overflow=0; sub 0x8000 - 0x0001 -> 0x7FFF, overflow=1.
REQ-037 Stream 8 random ops back-to-back, out_ready low 3 cycles mid-stream -> in_ready low same cycles, outputs held, all 8 results correct and in order.
REQ-038 Assert rst_n low with 3 ops in flight -> out_valid 0 immediately; after release, no stale results, next op correct at latency 4.
